// File: rtl/opchk_pkg.sv
// Shared types for the operator self-check sequencer: opcode and FSM state enums.
package opchk_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_EQ  = 3'd5,
        OP_LTU = 3'd6,
        OP_SHL = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_EXEC   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/op_check_seq_if.sv
// Vector input channel. Handshake: a vector transfers on a rising clk edge where
// in_valid && in_ready; the payload is only meaningful while in_valid is high.
interface op_check_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_expect;

    modport master (
        output in_valid, in_a, in_b, in_op, in_expect,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_expect,
        output in_ready
    );
endinterface

// File: rtl/opchk_alu.sv
// Combinational operator evaluation f(a, b, op) for the check sequencer.
module opchk_alu
    import opchk_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);
    localparam int SH_W = $clog2(WIDTH);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_EQ:   y = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_LTU:  y = {{(WIDTH-1){1'b0}}, (a < b)};
            // Only the low log2(WIDTH) bits of b select the shift distance.
            OP_SHL:  y = a << b[SH_W-1:0];
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/op_check_seq.sv
// Operator self-check sequencer: accepts NUM_VECTORS vectors, evaluates and compares each.
// Optional build macro OPCHK_STOP_ON_FAIL_EN ends the run at the first mismatch.
module op_check_seq
    import opchk_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int NUM_VECTORS = 8,
    localparam int CNT_W       = $clog2(NUM_VECTORS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    op_check_seq_if.slave     vin,
    output logic [WIDTH-1:0]  result,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic              any_fail,
    output state_e            dbg_state
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    state_e           state, state_n;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] a_q, b_q, exp_q;
    op_e              op_q;
    logic [WIDTH-1:0] alu_y;
    logic             mismatch;
    logic             go_done;

    opchk_alu #(.WIDTH(WIDTH)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    assign mismatch  = (result != exp_q);
    assign dbg_state = state;

`ifdef OPCHK_STOP_ON_FAIL_EN
    assign go_done = (idx == LAST_IDX) || mismatch;
`else
    assign go_done = (idx == LAST_IDX);
`endif

    always_comb begin
        state_n      = state;
        vin.in_ready = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_n = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                vin.in_ready = 1'b1;
                if (vin.in_valid) state_n = ST_EXEC;
            end
            ST_EXEC:  state_n = ST_CHECK;
            ST_CHECK: state_n = go_done ? ST_DONE : ST_ACCEPT;
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= OP_ADD;
            exp_q          <= '0;
            result         <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            any_fail       <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx            <= '0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_idx <= '0;
                        any_fail       <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    if (vin.in_valid) begin
                        a_q   <= vin.in_a;
                        b_q   <= vin.in_b;
                        op_q  <= op_e'(vin.in_op);
                        exp_q <= vin.in_expect;
                    end
                end
                ST_EXEC: result <= alu_y;
                ST_CHECK: begin
                    if (mismatch) begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                        if (!any_fail) begin
                            first_fail_idx <= idx;
                            any_fail       <= 1'b1;
                        end
                    end else begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end
                    if (!go_done) idx <= idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
